wb_regfile: RTL



---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/wb_regfile_if.sv | 37 +++
 rtl/wb_select.sv | 39 +++
 rtl/wb_regfile.sv | 89 ++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared widths and encodings for the write-back stage and register file.
package wb_regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 32;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;
  localparam logic [1:0] MTR_RSVD = 2'b11;

  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus, ID-stage read ports and debug observation signals.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic                inRegWrite;
  logic                inJalSel;
  logic [1:0]          inMemToReg;
  logic [DATA_W-1:0]   inAluResult;
  logic [DATA_W-1:0]   inMemReadData;
  logic [DATA_W-1:0]   inLinkAddr;
  logic [ADDR_W-1:0]   inWriteRegister;
  logic [ADDR_W-1:0]   ReadReg1;
  logic [ADDR_W-1:0]   ReadReg2;
  logic [DATA_W-1:0]   ReadData1;
  logic [DATA_W-1:0]   ReadData2;
  logic [DATA_W-1:0]   outWbData;
  logic [ADDR_W-1:0]   outWbReg;
  logic                outWbEn;
  logic [ADDR_W-1:0]   DebugLastReg;
  logic [DATA_W-1:0]   DebugLastData;
  logic [CNT_W-1:0]    DebugWbCount;

  modport slave (
    input  inRegWrite, inJalSel, inMemToReg, inAluResult, inMemReadData,
           inLinkAddr, inWriteRegister, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, outWbData, outWbReg, outWbEn,
           DebugLastReg, DebugLastData, DebugWbCount
  );

  modport master (
    output inRegWrite, inJalSel, inMemToReg, inAluResult, inMemReadData,
           inLinkAddr, inWriteRegister, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, outWbData, outWbReg, outWbEn,
           DebugLastReg, DebugLastData, DebugWbCount
  );

endinterface

// File: rtl/wb_select.sv
// Write-back value mux with JAL destination override; purely combinational.
module wb_select
  import wb_regfile_pkg::*;
(
  input  logic                reg_write,
  input  logic                jal_sel,
  input  logic [1:0]          mem_to_reg,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   mem_read_data,
  input  logic [DATA_W-1:0]   link_addr,
  input  logic [ADDR_W-1:0]   write_register,
  output logic [DATA_W-1:0]   wb_data,
  output logic [ADDR_W-1:0]   wb_reg,
  output logic                wb_en
);

  always_comb begin
    wb_data = alu_result;
    wb_reg  = write_register;
    wb_en   = 1'b0;

    unique case (mem_to_reg)
      MTR_MEM:  wb_data = mem_read_data;
      MTR_LINK: wb_data = link_addr;
      MTR_ALU,
      MTR_RSVD: wb_data = alu_result;
      default:  wb_data = alu_result;
    endcase

    // JAL always links into the fixed return-address register.
    if (jal_sel) begin
      wb_data = link_addr;
      wb_reg  = LINK_REG;
    end

    wb_en = reg_write && (wb_reg != REG_ZERO);
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file with write-first
// read bypass and registered debug state of the last committed write.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  wb_regfile_if.slave   bus
);

  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_reg;
  logic              wb_en;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] last_reg;
  logic [DATA_W-1:0] last_data;
  logic [CNT_W-1:0]  wb_count;

  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  wb_select u_select (
    .reg_write      (bus.inRegWrite),
    .jal_sel        (bus.inJalSel),
    .mem_to_reg     (bus.inMemToReg),
    .alu_result     (bus.inAluResult),
    .mem_read_data  (bus.inMemReadData),
    .link_addr      (bus.inLinkAddr),
    .write_register (bus.inWriteRegister),
    .wb_data        (wb_data),
    .wb_reg         (wb_reg),
    .wb_en          (wb_en)
  );

  // Register storage; wb_en already excludes $0 so it is never written.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Debug record of the most recent commit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_reg  <= '0;
      last_data <= '0;
      wb_count  <= '0;
    end else if (wb_en) begin
      last_reg  <= wb_reg;
      last_data <= wb_data;
      wb_count  <= wb_count + CNT_W'(1);
    end
  end

  // Write-first bypass, suppressed during reset; $0 always reads zero.
  always_comb begin
    read_data1 = regs[bus.ReadReg1];
    read_data2 = regs[bus.ReadReg2];

    if (wb_en && !Reset && (bus.ReadReg1 == wb_reg)) begin
      read_data1 = wb_data;
    end
    if (wb_en && !Reset && (bus.ReadReg2 == wb_reg)) begin
      read_data2 = wb_data;
    end

    if (Reset || (bus.ReadReg1 == REG_ZERO)) begin
      read_data1 = '0;
    end
    if (Reset || (bus.ReadReg2 == REG_ZERO)) begin
      read_data2 = '0;
    end
  end

  assign bus.ReadData1     = read_data1;
  assign bus.ReadData2     = read_data2;
  assign bus.outWbData     = wb_data;
  assign bus.outWbReg      = wb_reg;
  assign bus.outWbEn       = wb_en;
  assign bus.DebugLastReg  = last_reg;
  assign bus.DebugLastData = last_data;
  assign bus.DebugWbCount  = wb_count;

endmodule
